// File: rtl/bme280_i2c_slave.sv
// rtl/bme280_i2c_slave.sv - I2C slave exposing a BME280-style register map
module bme280_i2c_slave #(
  parameter logic [6:0] SLAVE_ADDRESS = 7'b111_0110,
  parameter logic [7:0] CHIP_ID       = 8'h60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_out,
  output logic        tristate,
  input  logic [19:0] press_raw,
  input  logic [19:0] temp_raw,
  input  logic [15:0] hum_raw,
  output logic [7:0]  ctrl_hum,
  output logic [7:0]  ctrl_meas,
  output logic [7:0]  config_reg,
  output logic        soft_reset,
  output logic        busy
);
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ADDR_ACK  = 4'd2;
  localparam logic [3:0] S_REG       = 4'd3;
  localparam logic [3:0] S_REG_ACK   = 4'd4;
  localparam logic [3:0] S_WDATA     = 4'd5;
  localparam logic [3:0] S_WDATA_ACK = 4'd6;
  localparam logic [3:0] S_RDATA     = 4'd7;
  localparam logic [3:0] S_RDATA_ACK = 4'd8;

  // pipe bit 0 = metastability flop, bit 1 = synced level, bit 2 = previous synced level
  logic [2:0]  scl_pipe_q, scl_pipe_d, sda_pipe_q, sda_pipe_d;
  logic [3:0]  state_q, state_d, bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d, pointer_q, pointer_d;
  logic        ack_phase_q, ack_phase_d, rw_q, rw_d;
  logic [7:0]  ctrl_hum_q, ctrl_hum_d, ctrl_meas_q, ctrl_meas_d, config_q, config_d;
  logic        soft_reset_q, soft_reset_d, sda_out_q, sda_out_d;
  logic        tristate_q, tristate_d, busy_q, busy_d;
  logic [19:0] press_snap_q, press_snap_d, temp_snap_q, temp_snap_d;
  logic [15:0] hum_snap_q, hum_snap_d;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] shift_in, rd_byte;

  assign scl_rise  = scl_pipe_q[1] & ~scl_pipe_q[2];
  assign scl_fall  = ~scl_pipe_q[1] & scl_pipe_q[2];
  assign start_det = scl_pipe_q[1] & scl_pipe_q[2] & sda_pipe_q[2] & ~sda_pipe_q[1];
  assign stop_det  = scl_pipe_q[1] & scl_pipe_q[2] & ~sda_pipe_q[2] & sda_pipe_q[1];
  assign shift_in  = {shift_q[6:0], sda_pipe_q[1]};

  always_comb begin
    rd_byte = 8'h00;
    case (pointer_q)
      8'hD0:   rd_byte = CHIP_ID;
      8'hF2:   rd_byte = ctrl_hum_q;
      8'hF4:   rd_byte = ctrl_meas_q;
      8'hF5:   rd_byte = config_q;
      8'hF7:   rd_byte = press_snap_q[19:12];
      8'hF8:   rd_byte = press_snap_q[11:4];
      8'hF9:   rd_byte = {press_snap_q[3:0], 4'h0};
      8'hFA:   rd_byte = temp_snap_q[19:12];
      8'hFB:   rd_byte = temp_snap_q[11:4];
      8'hFC:   rd_byte = {temp_snap_q[3:0], 4'h0};
      8'hFD:   rd_byte = hum_snap_q[15:8];
      8'hFE:   rd_byte = hum_snap_q[7:0];
      default: rd_byte = 8'h00;
    endcase
  end

  always_comb begin
    scl_pipe_d   = {scl_pipe_q[1:0], scl};
    sda_pipe_d   = {sda_pipe_q[1:0], sda_in};
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    ack_phase_d  = ack_phase_q;
    rw_d         = rw_q;
    pointer_d    = pointer_q;
    ctrl_hum_d   = ctrl_hum_q;
    ctrl_meas_d  = ctrl_meas_q;
    config_d     = config_q;
    soft_reset_d = 1'b0;
    sda_out_d    = sda_out_q;
    tristate_d   = tristate_q;
    press_snap_d = press_snap_q;
    temp_snap_d  = temp_snap_q;
    hum_snap_d   = hum_snap_q;

    if (start_det) begin
      state_d    = S_ADDR;
      bit_cnt_d  = 4'd0;
      tristate_d = 1'b1;
      sda_out_d  = 1'b1;
    end else if (stop_det) begin
      state_d    = S_IDLE;
      bit_cnt_d  = 4'd0;
      tristate_d = 1'b1;
      sda_out_d  = 1'b1;
    end else begin
      case (state_q)
        S_ADDR, S_REG, S_WDATA: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d   = 4'd0;
              ack_phase_d = 1'b0;
              if (state_q == S_ADDR) begin
                if (shift_in[7:1] == SLAVE_ADDRESS) begin
                  state_d = S_ADDR_ACK;
                  rw_d    = shift_in[0];
                  if (shift_in[0]) begin
                    press_snap_d = press_raw;
                    temp_snap_d  = temp_raw;
                    hum_snap_d   = hum_raw;
                  end
                end else begin
                  state_d = S_IDLE;
                end
              end else if (state_q == S_REG) begin
                pointer_d = shift_in;
                state_d   = S_REG_ACK;
              end else begin
                pointer_d = pointer_q + 8'd1;
                state_d   = S_WDATA_ACK;
                case (pointer_q)
                  8'hF2:   ctrl_hum_d  = shift_in;
                  8'hF4:   ctrl_meas_d = shift_in;
                  8'hF5:   config_d    = shift_in;
                  8'hE0: begin
                    if (shift_in == 8'hB6) begin
                      ctrl_hum_d   = 8'h00;
                      ctrl_meas_d  = 8'h00;
                      config_d     = 8'h00;
                      soft_reset_d = 1'b1;
                    end
                  end
                  default: ;
                endcase
              end
            end
          end
        end
        // first SCL fall enters the ACK slot, the second one leaves it
        S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              ack_phase_d = 1'b1;
              tristate_d  = 1'b0;
              sda_out_d   = 1'b0;
            end else begin
              ack_phase_d = 1'b0;
              bit_cnt_d   = 4'd0;
              if (state_q == S_ADDR_ACK && rw_q) begin
                state_d    = S_RDATA;
                tristate_d = 1'b0;
                sda_out_d  = rd_byte[7];
                shift_d    = {rd_byte[6:0], 1'b0};
              end else begin
                state_d    = (state_q == S_ADDR_ACK) ? S_REG : S_WDATA;
                tristate_d = 1'b1;
                sda_out_d  = 1'b1;
              end
            end
          end
        end
        S_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d    = S_RDATA_ACK;
              bit_cnt_d  = 4'd0;
              tristate_d = 1'b1;
              sda_out_d  = 1'b1;
            end else begin
              sda_out_d = shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
            end
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise) begin
            if (!sda_pipe_q[1]) begin
              pointer_d   = pointer_q + 8'd1;
              ack_phase_d = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else if (scl_fall && ack_phase_q) begin
            ack_phase_d = 1'b0;
            state_d     = S_RDATA;
            tristate_d  = 1'b0;
            sda_out_d   = rd_byte[7];
            shift_d     = {rd_byte[6:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_pipe_q   <= 3'b111;
      sda_pipe_q   <= 3'b111;
      state_q      <= S_IDLE;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'h00;
      ack_phase_q  <= 1'b0;
      rw_q         <= 1'b0;
      pointer_q    <= 8'h00;
      ctrl_hum_q   <= 8'h00;
      ctrl_meas_q  <= 8'h00;
      config_q     <= 8'h00;
      soft_reset_q <= 1'b0;
      sda_out_q    <= 1'b1;
      tristate_q   <= 1'b1;
      busy_q       <= 1'b0;
      press_snap_q <= 20'h0;
      temp_snap_q  <= 20'h0;
      hum_snap_q   <= 16'h0;
    end else begin
      scl_pipe_q   <= scl_pipe_d;
      sda_pipe_q   <= sda_pipe_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      ack_phase_q  <= ack_phase_d;
      rw_q         <= rw_d;
      pointer_q    <= pointer_d;
      ctrl_hum_q   <= ctrl_hum_d;
      ctrl_meas_q  <= ctrl_meas_d;
      config_q     <= config_d;
      soft_reset_q <= soft_reset_d;
      sda_out_q    <= sda_out_d;
      tristate_q   <= tristate_d;
      busy_q       <= busy_d;
      press_snap_q <= press_snap_d;
      temp_snap_q  <= temp_snap_d;
      hum_snap_q   <= hum_snap_d;
    end
  end

  assign sda_out    = sda_out_q;
  assign tristate   = tristate_q;
  assign ctrl_hum   = ctrl_hum_q;
  assign ctrl_meas  = ctrl_meas_q;
  assign config_reg = config_q;
  assign soft_reset = soft_reset_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_bme280_i2c_slave.sv
// tb/tb_bme280_i2c_slave.sv - randomized I2C master against a register-map model of bme280_i2c_slave
module tb_bme280_i2c_slave;
  localparam int Q = 50;

  logic        clk = 1'b0, rst = 1'b1, scl = 1'b1, m_sda = 1'b1;
  logic [19:0] press_raw = 20'h0, temp_raw = 20'h0;
  logic [15:0] hum_raw = 16'h0;
  logic        sda_out, tristate, soft_reset, busy, sda_line;
  logic [7:0]  ctrl_hum, ctrl_meas, config_reg;

  assign sda_line = m_sda & (tristate | sda_out);

  bme280_i2c_slave dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_line),
    .sda_out(sda_out), .tristate(tristate),
    .press_raw(press_raw), .temp_raw(temp_raw), .hum_raw(hum_raw),
    .ctrl_hum(ctrl_hum), .ctrl_meas(ctrl_meas), .config_reg(config_reg),
    .soft_reset(soft_reset), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int m_sr_pulses = 0, dut_sr_pulses = 0, sr_long = 0;
  bit mon_en = 1'b0, quiet = 1'b0, sr_prev = 1'b0;

  logic [7:0]  m_ptr = 8'h00, m_hum = 8'h00, m_meas = 8'h00, m_cfg = 8'h00;
  logic [19:0] s_press = 20'h0, s_temp = 20'h0;
  logic [15:0] s_hum = 16'h0;
  logic [7:0]  wbuf [4];
  logic [7:0]  rd_log [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // register map seen by a reader, from the snapshot and the model registers
  function automatic logic [7:0] mdl_read(input logic [7:0] a);
    case (a)
      8'hD0: return 8'h60;
      8'hF2: return m_hum;
      8'hF4: return m_meas;
      8'hF5: return m_cfg;
      8'hF7: return 8'((s_press / 4096) % 256);
      8'hF8: return 8'((s_press / 16) % 256);
      8'hF9: return 8'((s_press % 16) * 16);
      8'hFA: return 8'((s_temp / 4096) % 256);
      8'hFB: return 8'((s_temp / 16) % 256);
      8'hFC: return 8'((s_temp % 16) * 16);
      8'hFD: return 8'(s_hum / 256);
      8'hFE: return 8'(s_hum % 256);
      default: return 8'h00;
    endcase
  endfunction

  task automatic mdl_write(input logic [7:0] a, input logic [7:0] d);
    if (a == 8'hF2) m_hum = d;
    else if (a == 8'hF4) m_meas = d;
    else if (a == 8'hF5) m_cfg = d;
    else if (a == 8'hE0 && d == 8'hB6) begin
      m_hum = 8'h00; m_meas = 8'h00; m_cfg = 8'h00;
      m_sr_pulses++;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("ctrl_hum", ctrl_hum, m_hum);
      check("ctrl_meas", ctrl_meas, m_meas);
      check("config", config_reg, m_cfg);
    end
    if (quiet) check("sda_released", tristate, 1);
    if (soft_reset && !sr_prev) dut_sr_pulses++;
    if (soft_reset && sr_prev) sr_long++;
    sr_prev = soft_reset;
  end

  task automatic bit_xfer(input logic b, output logic r);
    #Q m_sda = b;
    #Q scl = 1'b1;
    #Q r = sda_line;
    #Q scl = 1'b0;
  endtask

  task automatic i2c_start();
    #Q m_sda = 1'b1;
    #Q scl = 1'b1;
    #Q m_sda = 1'b0;
    #Q scl = 1'b0;
  endtask

  task automatic i2c_stop();
    #Q m_sda = 1'b0;
    #Q scl = 1'b1;
    #Q m_sda = 1'b1;
    #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, r);
    ack = ~r;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] v);
    logic r;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_xfer(1'b1, r);
      v = {v[6:0], r};
    end
    bit_xfer(nack, r);
  endtask

  task automatic do_addr(input logic rw);
    logic a;
    send_byte({7'h76, rw}, a);
    check("addr_ack", a, 1);
    check("busy_in_txn", busy, 1);
    if (rw) begin
      s_press = press_raw; s_temp = temp_raw; s_hum = hum_raw;
    end
  endtask

  task automatic write_txn(input logic [7:0] ptr, input int n);
    logic a;
    i2c_start();
    do_addr(1'b0);
    send_byte(ptr, a);
    check("reg_ack", a, 1);
    m_ptr = ptr;
    for (int k = 0; k < n; k++) begin
      mon_en = 1'b0;
      send_byte(wbuf[k], a);
      check("wdata_ack", a, 1);
      mdl_write(m_ptr, wbuf[k]);
      m_ptr = m_ptr + 8'd1;
      mon_en = 1'b1;
    end
    i2c_stop();
    check("busy_after_stop", busy, 0);
  endtask

  task automatic read_txn(input bit set_ptr, input logic [7:0] ptr, input int n, input bit change_mid);
    logic a;
    logic [7:0] v;
    rd_log.delete();
    i2c_start();
    if (set_ptr) begin
      do_addr(1'b0);
      send_byte(ptr, a);
      check("reg_ack", a, 1);
      m_ptr = ptr;
      i2c_start();
    end
    do_addr(1'b1);
    for (int k = 0; k < n; k++) begin
      recv_byte(k == n - 1, v);
      check("rdata", v, mdl_read(m_ptr));
      rd_log.push_back(v);
      if (k != n - 1) m_ptr = m_ptr + 8'd1;
      if (change_mid) begin
        press_raw = press_raw ^ 20'hFFFFF;
        temp_raw  = 20'($urandom);
        hum_raw   = 16'($urandom);
      end
    end
    check("released_after_nack", tristate, 1);
    i2c_stop();
    check("busy_after_stop", busy, 0);
  endtask

  function automatic logic [7:0] pick_ptr();
    case ($urandom_range(0, 15))
      0: return 8'hD0;  1: return 8'hE0;  2: return 8'hF2;  3: return 8'hF4;
      4: return 8'hF5;  5: return 8'hF7;  6: return 8'hF8;  7: return 8'hF9;
      8: return 8'hFA;  9: return 8'hFB;  10: return 8'hFC; 11: return 8'hFD;
      12: return 8'hFE; 13: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    #950000;
    $display("FAIL watchdog simulation did not complete checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    logic a;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tristate", tristate, 1);
    check("rst_sda_out", sda_out, 1);
    check("rst_busy", busy, 0);
    check("rst_soft_reset", soft_reset, 0);
    check("rst_ctrl_hum", ctrl_hum, 0);
    check("rst_ctrl_meas", ctrl_meas, 0);
    check("rst_config", config_reg, 0);
    mon_en = 1'b1;

    wbuf[0] = 8'h03;
    write_txn(8'hF4, 1);
    check("ctrl_meas_03", ctrl_meas, 8'h03);

    read_txn(1'b1, 8'hD0, 1, 1'b0);
    check("chip_id", rd_log[0], 8'h60);

    press_raw = 20'hABCDE;
    read_txn(1'b1, 8'hF7, 3, 1'b1);
    check("press_msb", rd_log[0], 8'hAB);
    check("press_lsb", rd_log[1], 8'hCD);
    check("press_xlsb", rd_log[2], 8'hE0);

    quiet = 1'b1;
    i2c_start();
    send_byte(8'hEE, a);
    check("wrong_addr_nack", a, 0);
    i2c_stop();
    quiet = 1'b0;
    check("wrong_addr_busy", busy, 0);

    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    write_txn(8'hFF, 2);
    check("ptr_wrap_model", m_ptr, 8'h01);
    check("wrap_ctrl_meas", ctrl_meas, 8'h03);

    wbuf[0] = 8'h44;
    write_txn(8'hF3, 1);
    read_txn(1'b0, 8'h00, 1, 1'b0);
    check("ptr_retained", rd_log[0], 8'h03);

    wbuf[0] = 8'h12;
    write_txn(8'hE0, 1);
    check("no_sr_on_other_value", dut_sr_pulses, 0);
    wbuf[0] = 8'hB6;
    write_txn(8'hE0, 1);
    check("soft_reset_pulses", dut_sr_pulses, 1);
    check("soft_reset_clears", ctrl_meas, 8'h00);

    write_txn(8'hD0, 0);
    i2c_start();
    do_addr(1'b1);
    repeat (6) @(negedge clk);
    check("driving_before_rst", tristate, 0);
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("release_after_rst", tristate, 1);
    rst = 1'b0;
    m_ptr = 8'h00; m_hum = 8'h00; m_meas = 8'h00; m_cfg = 8'h00;
    i2c_stop();
    mon_en = 1'b1;
    check("busy_after_rst", busy, 0);

    for (int t = 0; t < 30; t++) begin
      press_raw = 20'($urandom);
      temp_raw  = 20'($urandom);
      hum_raw   = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        logic [7:0] p;
        int n;
        p = pick_ptr();
        n = $urandom_range(0, 3);
        for (int k = 0; k < 4; k++)
          wbuf[k] = (p == 8'hE0 && $urandom_range(0, 2) == 0) ? 8'hB6 : 8'($urandom);
        write_txn(p, n);
      end else begin
        read_txn($urandom_range(0, 3) != 0, pick_ptr(), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
      end
    end

    repeat (4) @(negedge clk);
    check("soft_reset_count", dut_sr_pulses, m_sr_pulses);
    check("soft_reset_width", sr_long, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bme280_i2c_slave.md
BME280_I2C_SLAVE -- requirements
Module: bme280_i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDRESS, default 7'b111_0110, the 7-bit device address it answers to.
REQ-002 SHALL have parameter CHIP_ID, default 8'h60, the value returned from register 0xD0.
REQ-003 clk  input  1  system clock; all logic single clock domain, rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 scl  input  1  I2C clock from master, asynchronous to clk.
REQ-006 sda_in  input  1  SDA line level, asynchronous to clk.
REQ-007 sda_out  output  1  SDA value driven when tristate=0.
REQ-008 tristate  output  1  1 = SDA released (high-Z); 0 = slave drives sda_out.
REQ-009 press_raw  input  20  pressure sample from sensor model.
REQ-010 temp_raw  input  20  temperature sample.
REQ-011 hum_raw  input  16  humidity sample.
REQ-012 ctrl_hum, ctrl_meas, config  output  8 each  current contents of registers 0xF2, 0xF4, 0xF5.
REQ-013 soft_reset  output  1  one-clk pulse on accepted write of 0xB6 to 0xE0.
REQ-014 busy  output  1  high from addressed START until STOP or NACK-released idle.

Function
REQ-015 scl and sda_in SHALL pass through 2-flop synchronizers; edges detected on synchronized values.
REQ-016 START = synced SDA falling while synced SCL high; STOP = synced SDA rising while synced SCL high; both SHALL be honoured in every state, START (incl. repeated START) going to ADDR, STOP to IDLE.
REQ-017 SDA bits SHALL be sampled on synced SCL rising edge, MSB first; sda_out/tristate SHALL change only the clk after a synced SCL falling edge.
REQ-018 FSM states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-019 ADDR: shift 8 bits; on match with SLAVE_ADDRESS go ADDR_ACK (drive 0 for one SCL period); mismatch -> IDLE, tristate held 1 until next START.
REQ-020 After ADDR_ACK: R/W=0 -> REG; R/W=1 -> RDATA.
REQ-021 REG: 8 bits loaded into register pointer, ACK, then WDATA.
REQ-022 WDATA: 8 bits written to pointer address, ACK, pointer +1, repeat.
REQ-023 RDATA: drive byte at pointer; RDATA_ACK samples master bit: 0 -> pointer +1, next byte; 1 (NACK) -> release, IDLE.
REQ-024 Pointer SHALL be 8 bits, wrap 0xFF -> 0x00, retained across STOP/repeated START.
REQ-025 On ADDR_ACK with R/W=1, press_raw/temp_raw/hum_raw SHALL be snapshotted; whole burst returns the snapshot.
REQ-026 Read map: 0xD0 CHIP_ID; 0xF2/F4/F5 register; 0xF7 press[19:12], 0xF8 press[11:4], 0xF9 {press[3:0],4'h0}; 0xFA-0xFC same for temp; 0xFD hum[15:8]; 0xFE hum[7:0]; all others 0x00.
REQ-027 Writes SHALL affect only 0xF2, 0xF4, 0xF5 and 0xE0; other addresses ACKed and ignored.
REQ-028 Write 0xB6 to 0xE0 SHALL clear ctrl_hum, ctrl_meas, config to 0x00 and pulse soft_reset the clk after the data byte's 8th bit is sampled; any other value ignored.
REQ-029 Data bytes SHALL always be ACKed; slave never NACKs an addressed write.

Reset
REQ-030 rst SHALL force IDLE, tristate=1, sda_out=1, busy=0, soft_reset=0, pointer=0x00, ctrl_hum=ctrl_meas=config=0x00, shift/bit counters 0.
REQ-031 rst asserted mid-transfer SHALL release SDA the next clk; slave ignores bus until next START.

Verification
REQ-032 START, 0xEC, ACK, 0xF4, 0x03, STOP -> three slave ACKs; ctrl_meas=0x03.
REQ-033 START, 0xEC, 0xD0, repeated START, 0xED, master NACK -> slave returns 0x60, tristate=1 after NACK.
REQ-034 press_raw=20'hABCDE; write ptr 0xF7, read 3 bytes ACK,ACK,NACK -> 0xAB, 0xCD, 0xE0; changing press_raw mid-burst does not alter returned bytes.
REQ-035 START, 0xEE (wrong address) -> tristate stays 1 through ACK slot; no register change.
REQ-036 Write ptr 0xFF, data 0x11, 0x22 -> pointer wraps to 0x00, then 0x01; no register change; all ACKed.
REQ-037 ctrl_meas=0x03, write 0xB6 to 0xE0 -> soft_reset one-clk pulse, ctrl_meas=0x00; rst during RDATA -> tristate=1 next clk.
